// File: rtl/cnn_inst_queue.sv
// Instruction queue between the CNN instruction port and the parser: buffers
// data words in a FIFO and issues them one at a time on START.
module cnn_inst_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [127:0]  cnn_inst,
    input  logic          cnn_inst_en,
    input  logic          parser_ready,
    output logic          exec_valid,
    output logic [3:0]    exec_op,
    output logic [31:0]   exec_src1,
    output logic [31:0]   exec_src2,
    output logic [31:0]   exec_dest,
    output logic [27:0]   exec_param,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   level
);
    // state | meaning
    // IDLE  | waiting for START, writes still accepted
    // ISSUE | waiting for parser_ready, then issue the FIFO head
    // ACK   | waiting for the parser to drop ready (bounded wait)
    // BUSYW | waiting for the parser to raise ready again
    typedef enum logic [1:0] {IDLE, ISSUE, ACK, BUSYW} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [7:0]  ACK_LOAD = 8'd254;

    state_t        state;
    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    ack_cnt;
    logic [127:0]  head;
    logic          is_ctrl;
    logic          cmd_clear;
    logic          cmd_start;
    logic          wr_data;
    logic          full;
    logic          push;
    logic          pop;

    assign is_ctrl   = (cnn_inst[127:8] == '0) &&
                       ((cnn_inst[7:0] == 8'd1) || (cnn_inst[7:0] == 8'd2));
    assign cmd_clear = cnn_inst_en && is_ctrl && (cnn_inst[7:0] == 8'd1);
    assign cmd_start = cnn_inst_en && is_ctrl && (cnn_inst[7:0] == 8'd2);
    assign wr_data   = cnn_inst_en && !is_ctrl;
    assign full      = (level == FULL_LVL);
    assign push      = wr_data && !full;
    // A CLEAR arriving in ISSUE wins over the pop; nothing is in flight yet.
    assign pop       = (state == ISSUE) && parser_ready && (level != '0) && !cmd_clear;
    assign head      = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= cnn_inst;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ack_cnt    <= '0;
            overflow   <= 1'b0;
            exec_valid <= 1'b0;
            exec_op    <= '0;
            exec_src1  <= '0;
            exec_src2  <= '0;
            exec_dest  <= '0;
            exec_param <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            exec_valid <= 1'b0;
            done       <= 1'b0;

            if (cmd_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_data && full) overflow <= 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end

            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        if (level != '0) begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_clear || level == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (parser_ready) begin
                        exec_valid <= 1'b1;
                        exec_op    <= head[127:124];
                        exec_src1  <= head[123:92];
                        exec_src2  <= head[91:60];
                        exec_dest  <= head[59:28];
                        exec_param <= head[27:0];
                        ack_cnt    <= ACK_LOAD;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    // Timeout after 255 cycles covers instructions the parser finishes instantly.
                    if (!parser_ready || ack_cnt == '0) begin
                        state <= BUSYW;
                    end else begin
                        ack_cnt <= ack_cnt - 1'b1;
                    end
                end
                BUSYW: begin
                    if (parser_ready) begin
                        if (level != '0 && !cmd_clear) begin
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_inst_queue.sv
// Scoreboard bench for cnn_inst_queue: a plain queue models the FIFO, a monitor
// pops it on every issue pulse, and a parser model drives the ready handshake.
module tb_cnn_inst_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [127:0]  cnn_inst;
    logic          cnn_inst_en;
    logic          parser_ready;
    logic          exec_valid;
    logic [3:0]    exec_op;
    logic [31:0]   exec_src1;
    logic [31:0]   exec_src2;
    logic [31:0]   exec_dest;
    logic [27:0]   exec_param;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   level;

    cnn_inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .cnn_inst(cnn_inst), .cnn_inst_en(cnn_inst_en),
        .parser_ready(parser_ready), .exec_valid(exec_valid), .exec_op(exec_op),
        .exec_src1(exec_src1), .exec_src2(exec_src2), .exec_dest(exec_dest),
        .exec_param(exec_param), .busy(busy), .done(done), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    logic [127:0] model_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_issue = 0;
    int n_done = 0;
    int cyc = 0;
    int last_issue_cyc = 0;
    int prev_issue_cyc = 0;
    int pmode = 0;      // 0: drop ready 2 cycles after issue, 1: ready stuck high, 2: bench drives ready
    int busy_len = 50;

    localparam logic [127:0] CLEAR_W = 128'd1;
    localparam logic [127:0] START_W = 128'd2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exec_valid) begin
            logic [127:0] e;
            n_issue++;
            prev_issue_cyc = last_issue_cyc;
            last_issue_cyc = cyc;
            if (model_q.size() == 0) begin
                check("spurious_issue", 1, 0);
            end else begin
                e = model_q.pop_front();
                check("exec_op",    exec_op,    e[127:124]);
                check("exec_src1",  exec_src1,  e[123:92]);
                check("exec_src2",  exec_src2,  e[91:60]);
                check("exec_dest",  exec_dest,  e[59:28]);
                check("exec_param", exec_param, e[27:0]);
            end
        end
        if (done) n_done++;
    end

    // Parser model
    always begin
        @(negedge clk);
        if (exec_valid && pmode == 0) begin
            repeat (2) @(posedge clk);
            #1 parser_ready = 1'b0;
            repeat (busy_len) @(posedge clk);
            #1 parser_ready = 1'b1;
        end
    end

    function automatic logic [127:0] rand_word();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[100] = 1'b1;  // guarantees it can never decode as a control word
        return w;
    endfunction

    task automatic send(input logic [127:0] w);
        cnn_inst = w;
        cnn_inst_en = 1'b1;
        @(negedge clk);
        cnn_inst_en = 1'b0;
        cnn_inst = '0;
    endtask

    task automatic push_data(input logic [127:0] w);
        if (model_q.size() < DEPTH) model_q.push_back(w);
        send(w);
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic wait_issue(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (exec_valid) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  exec_valid, 0);
        check({tag, "_op"},     exec_op,    0);
        check({tag, "_src1"},   exec_src1,  0);
        check({tag, "_src2"},   exec_src2,  0);
        check({tag, "_dest"},   exec_dest,  0);
        check({tag, "_param"},  exec_param, 0);
        check({tag, "_busy"},   busy,       0);
        check({tag, "_done"},   done,       0);
        check({tag, "_ovf"},    overflow,   0);
        check({tag, "_level"},  level,      0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, d0, n, extra;
        logic [127:0] w;

        sys_rst = 1'b1; cnn_inst = '0; cnn_inst_en = 1'b0; parser_ready = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Three words: add, addi (src2 = 1000), conv (p2 = p3 = 3)
        pmode = 0; busy_len = 50;
        w = rand_word(); w[127:124] = 4'd0; push_data(w);
        w = rand_word(); w[127:124] = 4'd1; w[91:60] = 32'd1000; push_data(w);
        w = rand_word(); w[127:124] = 4'd7; w[11:6] = 6'd3; w[5:0] = 6'd3; push_data(w);
        check("three_level", level, 3);
        i0 = n_issue; d0 = n_done;
        send(START_W);
        wait_done("three_done", 1000);
        repeat (5) @(negedge clk);
        check("three_issues", n_issue - i0, 3);
        check("three_done_cnt", n_done - d0, 1);
        check("three_level_end", level, 0);
        check("three_busy_end", busy, 0);

        // Overflow with DEPTH+2 writes, then CLEAR
        for (int k = 0; k < DEPTH + 2; k++) push_data(rand_word());
        check("ovf_level", level, model_q.size());
        check("ovf_flag", overflow, 1);
        send(CLEAR_W);
        model_q.delete();
        check("clr_level", level, 0);
        check("clr_ovf", overflow, 0);

        // START on an empty queue
        i0 = n_issue;
        send(START_W);
        check("empty_done", done, 1);
        check("empty_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("empty_busy_later", busy, 0);
        check("empty_no_issue", n_issue - i0, 0);

        // Mult word parameter slice
        busy_len = 5;
        push_data({4'h4, 32'h0400_0000, 32'h0500_0000, 32'h0800_0000, 8'd5, 8'd3, 8'd7, 4'h0});
        send(START_W);
        wait_done("mult_done", 500);
        check("mult_param", exec_param, 28'h0503070);
        check("mult_op", exec_op, 4'h4);

        // Ready held low at START
        pmode = 2; parser_ready = 1'b0;
        push_data(rand_word());
        i0 = n_issue;
        send(START_W);
        repeat (20) @(negedge clk);
        check("lowrdy_no_issue", n_issue - i0, 0);
        check("lowrdy_busy", busy, 1);
        pmode = 0; busy_len = 8; parser_ready = 1'b1;
        @(negedge clk);
        check("lowrdy_issue", exec_valid, 1);
        wait_done("lowrdy_done", 500);

        // Parser never drops ready: ACK timeout
        pmode = 1; parser_ready = 1'b1;
        push_data(rand_word());
        push_data(rand_word());
        i0 = n_issue;
        send(START_W);
        wait_done("tmo_done", 1500);
        check("tmo_issues", n_issue - i0, 2);
        check("tmo_spacing", last_issue_cyc - prev_issue_cyc, 257);

        // CLEAR during BUSYW with two entries queued
        pmode = 0; busy_len = 40;
        for (int k = 0; k < 3; k++) push_data(rand_word());
        i0 = n_issue; d0 = n_done;
        send(START_W);
        wait_issue("bclr_first", 50);
        repeat (10) @(negedge clk);
        check("bclr_busy_before", busy, 1);
        send(CLEAR_W);
        model_q.delete();
        wait_done("bclr_done", 500);
        check("bclr_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("bclr_issues", n_issue - i0, 1);
        check("bclr_done_cnt", n_done - d0, 1);
        check("bclr_level", level, 0);

        // Reset during ACK
        pmode = 1; parser_ready = 1'b1;
        push_data(rand_word());
        push_data(rand_word());
        send(START_W);
        wait_issue("rst_first", 50);
        repeat (5) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        model_q.delete();
        check_zero("midrst");
        pmode = 0;

        // Randomized rounds, including writes while issuing
        for (int r = 0; r < 8; r++) begin
            busy_len = $urandom_range(1, 20);
            n = $urandom_range(1, 5);
            extra = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) push_data(rand_word());
            i0 = n_issue;
            send(START_W);
            for (int k = 0; k < extra; k++) push_data(rand_word());
            wait_done("rnd_done", 3000);
            check("rnd_issues", n_issue - i0, n + extra);
            check("rnd_level", level, 0);
            check("rnd_model_empty", model_q.size(), 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
